// File: rtl/z80_arb_pkg.sv
// Shared types and helpers for the Z80 shared-RAM arbiter.
// Holds the per-requester state encoding and the address-window hit test.
package z80_arb_pkg;

    localparam int unsigned MAX_REQ = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPend = 2'd1,
        StInfl = 2'd2,
        StDone = 2'd3
    } arb_state_e;

    // Active memory cycle whose address falls inside the shared window.
    function automatic logic win_hit(input logic        mreq_n,
                                     input logic        rd_n,
                                     input logic        wr_n,
                                     input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] mask);
        return !mreq_n && (!rd_n || !wr_n) && ((addr & mask) == (base & mask));
    endfunction

endpackage

// File: rtl/z80_shared_ram_arbiter_if.sv
// CPU-side and RAM-side bus bundle of the shared-RAM arbiter.
// The slave modport is the arbiter's view, master is the CPUs plus RAM.
interface z80_shared_ram_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned AW      = 11
);
    logic [NUM_REQ-1:0]    req_mreq_n;
    logic [NUM_REQ-1:0]    req_rd_n;
    logic [NUM_REQ-1:0]    req_wr_n;
    logic [NUM_REQ*16-1:0] req_addr;
    logic [NUM_REQ*8-1:0]  req_dout;
    logic [NUM_REQ-1:0]    req_wait_n;
    logic [NUM_REQ*8-1:0]  req_din;
    logic [NUM_REQ-1:0]    req_sel;
    logic [AW-1:0]         ram_addr;
    logic                  ram_we;
    logic [7:0]            ram_wdata;
    logic [7:0]            ram_rdata;
    logic [1:0]            grant_id;
    logic                  grant_vld;

    modport slave (
        input  req_mreq_n, req_rd_n, req_wr_n, req_addr, req_dout, ram_rdata,
        output req_wait_n, req_din, req_sel, ram_addr, ram_we, ram_wdata, grant_id, grant_vld
    );

    modport master (
        output req_mreq_n, req_rd_n, req_wr_n, req_addr, req_dout, ram_rdata,
        input  req_wait_n, req_din, req_sel, ram_addr, ram_we, ram_wdata, grant_id, grant_vld
    );

endinterface

// File: rtl/z80_arb_rr.sv
// Round-robin picker: first pending requester at or after rr_ptr_i wins.
module z80_arb_rr #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [1:0]         rr_ptr_i,
    output logic [NUM_REQ-1:0] winner_oh_o,
    output logic [1:0]         winner_idx_o,
    output logic               valid_o
);

    always_comb begin
        logic       found;
        logic [2:0] sum;
        logic [1:0] idx;
        winner_oh_o  = '0;
        winner_idx_o = 2'd0;
        found        = 1'b0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            sum = {1'b0, rr_ptr_i} + 3'(off);
            if (sum >= 3'(NUM_REQ)) begin
                sum = sum - 3'(NUM_REQ);
            end
            idx = sum[1:0];
            if (!found && pending_i[idx]) begin
                found             = 1'b1;
                winner_oh_o[idx]  = 1'b1;
                winner_idx_o      = idx;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/z80_shared_ram_arbiter.sv
// Arbitrates NUM_REQ wait-stretched Z80 buses onto one synchronous shared RAM,
// one round-robin grant per clock; each bus cycle yields exactly one RAM access.
module z80_shared_ram_arbiter
    import z80_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned AW       = 11,
    parameter logic [15:0] WIN_BASE = 16'h8800,
    parameter logic [15:0] WIN_MASK = 16'hF800
) (
    input logic                      clk,
    input logic                      reset_n,
    z80_shared_ram_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0] hit;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] win_oh;
    logic [1:0]         win_idx;
    logic               win_vld;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [AW-1:0]      mux_addr;
    logic [7:0]         mux_wdata;
    logic               mux_we;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_req
        arb_state_e state_q, state_d;
        logic [7:0] hold_q, hold_d;

        assign hit[g] = win_hit(bus.req_mreq_n[g], bus.req_rd_n[g], bus.req_wr_n[g],
                                bus.req_addr[16*g +: 16], WIN_BASE, WIN_MASK);
        // Gated by reset so nothing is granted (or written) while reset is held.
        assign pending[g] = reset_n & hit[g] & ((state_q == StIdle) | (state_q == StPend));
        assign bus.req_wait_n[g]       = !(hit[g] && (state_q != StDone));
        assign bus.req_sel[g]          = hit[g];
        assign bus.req_din[8*g +: 8]   = hold_q;

        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            if (!hit[g]) begin
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle: state_d = win_oh[g] ? StInfl : StPend;
                    StPend: if (win_oh[g]) state_d = StInfl;
                    StInfl: begin
                        state_d = StDone;
                        if (!bus.req_rd_n[g]) hold_d = bus.ram_rdata;
                    end
                    StDone: state_d = StDone;
                    default: state_d = StIdle;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= StIdle;
                hold_q  <= 8'h00;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
            end
        end
    end

    z80_arb_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .pending_i    (pending),
        .rr_ptr_i     (rr_ptr_q),
        .winner_oh_o  (win_oh),
        .winner_idx_o (win_idx),
        .valid_o      (win_vld)
    );

    always_comb begin
        mux_addr  = addr_q;
        mux_wdata = wdata_q;
        mux_we    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rr_ptr_d  = rr_ptr_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_oh[i]) begin
                mux_addr  = bus.req_addr[16*i +: AW];
                mux_wdata = bus.req_dout[8*i +: 8];
                // Read wins when both strobes are low.
                mux_we    = reset_n & bus.req_rd_n[i] & ~bus.req_wr_n[i];
            end
        end
        if (win_vld) begin
            addr_d   = mux_addr;
            wdata_d  = mux_wdata;
            rr_ptr_d = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
        end
    end

    assign bus.ram_addr  = mux_addr;
    assign bus.ram_wdata = mux_wdata;
    assign bus.ram_we    = mux_we;
    assign bus.grant_vld = win_vld;
    assign bus.grant_id  = win_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 8'h00;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: doc/z80_shared_ram_arbiter.md
Name: z80_shared_ram_arbiter

Overview:
- Shares one single-port, synchronous shared-work RAM between NUM_REQ tv80s-style CPU buses (e.g. the main, sub and sound CPUs in Galaga-class boards).
- Each CPU's in-window access is stretched with wait_n until the arbiter services it.
- Arbitration is round-robin, one RAM access per clock.
- Sits between the CPU cores and the shared RAM; out-of-window cycles pass through untouched. The top level muxes them using req_sel.

Parameters:
- NUM_REQ, 3, number of CPU requesters (2..4).
- AW, 11, shared RAM address width.
- WIN_BASE, 16'h8800, CPU address that maps to RAM word 0.
- WIN_MASK, 16'hF800, address bits compared against WIN_BASE for a window hit.

Ports:
- clk  in  1  system clock, all CPU cores clocked with cen=1.
- reset_n  in  1  asynchronous active-low reset.
- req_mreq_n  in  NUM_REQ  per-CPU mreq_n.
- req_rd_n  in  NUM_REQ  per-CPU rd_n.
- req_wr_n  in  NUM_REQ  per-CPU wr_n.
- req_addr  in  NUM_REQ*16  per-CPU A, requester i at bits [16i+15:16i].
- req_dout  in  NUM_REQ*8  per-CPU do.
- req_wait_n  out  NUM_REQ  per-CPU wait_n.
- req_din  out  NUM_REQ*8  per-CPU read data, held.
- req_sel  out  NUM_REQ  1 = requester i currently in-window; top level uses this to mux req_din into the CPU di.
- ram_addr  out  AW  shared RAM address.
- ram_we  out  1  shared RAM write strobe.
- ram_wdata  out  8  shared RAM write data.
- ram_rdata  in  8  shared RAM read data, valid the cycle after the address.
- grant_id  out  2  index of the requester granted this cycle (debug).
- grant_vld  out  1  a grant is issued this cycle.

Behaviour:
- Hit (combinational): hit_i = !req_mreq_n[i] & (!req_rd_n[i] | !req_wr_n[i]) & ((req_addr_i & WIN_MASK) == (WIN_BASE & WIN_MASK)). req_sel[i] = hit_i.
- Per-requester FSM, states IDLE, PEND, INFL, DONE. Encoding lives in the package.
  - IDLE -> PEND when hit_i.
  - PEND -> INFL when granted.
  - INFL -> DONE at the next edge. On that edge, a read also latches ram_rdata into hold_i.
  - DONE -> IDLE when hit_i drops, i.e. the strobes release.
  - Any state -> IDLE when hit_i drops before DONE. This abandons the access; an in-flight write is still committed.
- Wait (combinational, same cycle): req_wait_n[i] = !(hit_i & state_i != DONE).
  - Wait must be low in the very cycle rd_n/wr_n first go low, because tv80s samples wait_n at T2.
- pending_i = hit_i & state_i in {IDLE, PEND}. A requester in IDLE with hit_i is grantable that same cycle.
- Arbitration (combinational):
  - Round-robin over pending, starting at rr_ptr.
  - The winner drives ram_addr = req_addr_i[AW-1:0], ram_wdata = req_dout_i, ram_we = !req_rd_n[i] ? 0 : !req_wr_n[i].
  - If rd_n and wr_n are both low, read wins and no write occurs.
  - grant_vld = |pending.
  - rr_ptr <= winner+1, modulo NUM_REQ, on each grant.
- Latency: uncontended read = 2 wait cycles.
  - Hit in cycle R, grant in R, ram_rdata valid in R+1, hold/DONE at the R+1 edge, wait_n high from R+2.
  - Writes have the same latency.
  - Worst case with k contenders adds k-1 cycles.
- Throughput: one grant per cycle, back-to-back grants to different requesters allowed. A requester is never re-granted in INFL or DONE, so each bus cycle produces exactly one RAM access.
- req_din[i] = hold_i. It is stable from DONE until the next read completes.
- Reset values:
  - all FSMs IDLE, rr_ptr=0, hold_i=8'h00;
  - req_wait_n all 1 unless hit, req_din 0;
  - ram_we 0 when no hit, grant_vld 0, grant_id 0.
- Reset mid-operation returns everything to the reset values immediately. No RAM write is issued while reset_n is low: ram_we is gated by reset_n.
- When no grant, ram_addr/ram_wdata hold the last driven value and ram_we=0.

Decomposition:
- Package z80_arb_pkg holds:
  - the state enum (IDLE=2'd0, PEND=2'd1, INFL=2'd2, DONE=2'd3);
  - a function computing the window hit;
  - the MAX_REQ=4 constant.
- One natural sub-module: z80_arb_rr, a NUM_REQ-wide round-robin picker with pending, rr_ptr in and winner one-hot/index/valid out.
- The per-requester FSM is a generate loop in the top level.

Test Plan:
- Single read: CPU0 reads 16'h8805, RAM[5]=8'hA5 -> wait_n0 low for 2 cycles, req_din0=8'hA5, exactly one grant.
- Single write: CPU1 writes 8'h3C to 16'h8FFF -> ram_we for one cycle with ram_addr=11'h7FF; a following read returns 8'h3C.
- Three-way contention: all CPUs hit in the same cycle with rr_ptr=0 -> grants in order 0,1,2 on consecutive cycles; wait_n releases at cycles +2, +3, +4.
- Fairness: CPU0 and CPU2 hit continuously -> grants alternate 0,2,0,2 and neither waits more than 3 cycles.
- Out-of-window access 16'h1234 -> req_sel=0, wait_n stays 1, no grant.
- Reset asserted while CPU2 is in INFL for a write -> all FSMs IDLE, wait_n=1, ram_we=0 during reset, no duplicate write after release.
